// File: rtl/conv_encoder_pkg.sv
// IEEE 802.11a definitions shared by the convolutional encoder: RATE field codes,
// K=7 generator polynomials, puncture keep-masks and the rate-to-code-rate map.
// Latency: n/a (constants and pure functions only). Backpressure: n/a.
package conv_encoder_pkg;

   // SIGNAL-field RATE codes (4 bits, as transmitted in the PLCP header)
   localparam logic [3:0] RATE_6M  = 4'b1011;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b1010;
   localparam logic [3:0] RATE_18M = 4'b1110;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1101;
   localparam logic [3:0] RATE_48M = 4'b1000;
   localparam logic [3:0] RATE_54M = 4'b1100;

   // Generators applied to {newest bit, state[5:0]}; state[5] is the previous bit
   localparam logic [6:0] G0 = 7'o133;
   localparam logic [6:0] G1 = 7'o171;

   // Keep-masks over one puncture period of the unpunctured stream,
   // bit 0 = A0, bit 1 = B0, bit 2 = A1, ...
   localparam logic [3:0] PUNC_23_MASK = 4'b0111;   // A0 B0 A1
   localparam logic [5:0] PUNC_34_MASK = 6'b100111; // A0 B0 A1 B2

   typedef enum logic [1:0] {
      CR_1_2,
      CR_2_3,
      CR_3_4
   } code_rate_t;

   // Unknown codes fall back to rate 1/2
   function automatic code_rate_t code_rate(input logic [3:0] rate);
      code_rate_t cr;
      case (rate)
         RATE_48M:                              cr = CR_2_3;
         RATE_9M, RATE_18M, RATE_36M, RATE_54M: cr = CR_3_4;
         default:                               cr = CR_1_2;
      endcase
      return cr;
   endfunction

endpackage

// File: rtl/conv_encoder_skid.sv
// Generic 2-entry valid/ready skid buffer (output register + skid register).
// Latency: 1 cycle from accept to output. Backpressure: s_rdy_o is registered
// (= skid empty), so there is no combinational path from m_rdy_i to s_rdy_o.
// Ports: clk_i/rst_i (async active-high), s_vld_i/s_rdy_o/s_dat_i upstream,
// m_vld_o/m_rdy_i/m_dat_o downstream.
module conv_encoder_skid #(
   parameter int PW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          s_vld_i,
   output logic          s_rdy_o,
   input  logic [PW-1:0] s_dat_i,
   output logic          m_vld_o,
   input  logic          m_rdy_i,
   output logic [PW-1:0] m_dat_o
);

   logic          out_vld_q, out_vld_d;
   logic [PW-1:0] out_dat_q, out_dat_d;
   logic          skid_vld_q, skid_vld_d;
   logic [PW-1:0] skid_dat_q, skid_dat_d;
   logic          rdy_q;
   logic          push, pop;

   assign push = s_vld_i && rdy_q;
   assign pop  = out_vld_q && m_rdy_i;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (skid_vld_q) begin
         // Output is necessarily full here; refill it from skid when it pops
         if (pop) begin
            out_dat_d  = skid_dat_q;
            skid_vld_d = 1'b0;
         end
      end else if (push) begin
         if (!out_vld_q || pop) begin
            out_vld_d = 1'b1;
            out_dat_d = s_dat_i;
         end else begin
            skid_vld_d = 1'b1;
            skid_dat_d = s_dat_i;
         end
      end else if (pop) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
         rdy_q      <= 1'b0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
         rdy_q      <= !skid_vld_d;
      end
   end

   assign s_rdy_o = rdy_q;
   assign m_vld_o = out_vld_q;
   assign m_dat_o = out_dat_q;

endmodule

// File: rtl/conv_encoder.sv
// 802.11a K=7 convolutional encoder with 1/2, 2/3, 3/4 puncturing on AXI-Stream.
// Latency: 1 cycle (registered output), 1 beat/cycle. Backpressure: 2-entry skid,
// s_axis_tready registered; puncturing compiled in only with ENCODER_PUNCTURE_EN.
// Ports: aclk/areset; s_axis_{tdata,tuser,tvalid,tready,tlast} in (WIDTH bits,
// bit 0 first); m_axis_{tdata,tcount,tuser,tvalid,tready,tlast} out (LSB-aligned).
module conv_encoder
   import conv_encoder_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int CW    = $clog2(2*WIDTH+1)
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [WIDTH-1:0]   s_axis_tdata,
   input  logic [3:0]         s_axis_tuser,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   output logic [2*WIDTH-1:0] m_axis_tdata,
   output logic [CW-1:0]      m_axis_tcount,
   output logic [3:0]         m_axis_tuser,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast
);

   localparam int PW = 2*WIDTH + CW + 4 + 1;
   localparam logic [CW-1:0] CNT_1_2 = CW'(2*WIDTH);

   logic [5:0]         state_q, state_d, enc_state;
   logic               lock_q;
   logic [3:0]         rate_q, rate_eff;
   logic               accept;
   logic [2*WIDTH-1:0] raw, enc_dat;
   logic [CW-1:0]      enc_cnt;
   logic [PW-1:0]      skid_in, skid_out;

   assign accept   = s_axis_tvalid && s_axis_tready;
   // Rate is taken from the first beat of a frame and held until its tlast beat
   assign rate_eff = lock_q ? rate_q : s_axis_tuser;

   // Unpunctured A/B stream, A_i at bit 2i, B_i at bit 2i+1
   always_comb begin
      enc_state = state_q;
      raw       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         raw[2*i]   = ^(G0 & {s_axis_tdata[i], enc_state});
         raw[2*i+1] = ^(G1 & {s_axis_tdata[i], enc_state});
         enc_state  = {s_axis_tdata[i], enc_state[5:1]};
      end
   end

   // Every frame starts from the zero state
   assign state_d = s_axis_tlast ? 6'd0 : enc_state;

`ifdef ENCODER_PUNCTURE_EN
   localparam logic [CW-1:0] CNT_2_3 = CW'(3*WIDTH/2);
   localparam logic [CW-1:0] CNT_3_4 = CW'(4*WIDTH/3);

   logic [2*WIDTH-1:0] punc23, punc34;

   // Compact kept bits of each puncture period; WIDTH % 6 == 0 keeps periods beat-aligned
   always_comb begin
      int k;
      punc23 = '0;
      punc34 = '0;
      k      = 0;
      for (int g = 0; g < WIDTH/2; g++) begin
         k = 0;
         for (int j = 0; j < 4; j++) begin
            if (PUNC_23_MASK[j]) begin
               punc23[3*g+k] = raw[4*g+j];
               k++;
            end
         end
      end
      for (int g = 0; g < WIDTH/3; g++) begin
         k = 0;
         for (int j = 0; j < 6; j++) begin
            if (PUNC_34_MASK[j]) begin
               punc34[4*g+k] = raw[6*g+j];
               k++;
            end
         end
      end
   end

   always_comb begin
      enc_dat = raw;
      enc_cnt = CNT_1_2;
      case (code_rate(rate_eff))
         CR_2_3: begin
            enc_dat = punc23;
            enc_cnt = CNT_2_3;
         end
         CR_3_4: begin
            enc_dat = punc34;
            enc_cnt = CNT_3_4;
         end
         default: ;
      endcase
   end
`else
   assign enc_dat = raw;
   assign enc_cnt = CNT_1_2;
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= '0;
         lock_q  <= 1'b0;
         rate_q  <= '0;
      end else if (accept) begin
         state_q <= state_d;
         lock_q  <= !s_axis_tlast;
         rate_q  <= rate_eff;
      end
   end

   assign skid_in = {enc_dat, enc_cnt, rate_eff, s_axis_tlast};

   conv_encoder_skid #(
      .PW (PW)
   ) u_skid (
      .clk_i   (aclk),
      .rst_i   (areset),
      .s_vld_i (s_axis_tvalid),
      .s_rdy_o (s_axis_tready),
      .s_dat_i (skid_in),
      .m_vld_o (m_axis_tvalid),
      .m_rdy_i (m_axis_tready),
      .m_dat_o (skid_out)
   );

   assign {m_axis_tdata, m_axis_tcount, m_axis_tuser, m_axis_tlast} = skid_out;

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Parametrised IEEE 802.11a convolutional encoder (K=7, g0=133₈, g1=171₈) with rate-dependent puncturing to 1/2, 2/3 or 3/4. It sits between the scrambler and the interleaver on AXI-Stream, consumes WIDTH data bits per beat and emits the coded, punctured bits per beat with an explicit valid-bit count. It tracks frames via tlast and sustains full throughput under backpressure through an internal skid buffer.

## Interface
- WIDTH, 24: input bits per beat; must be a multiple of 6.
- CW, $clog2(2*WIDTH+1): width of the output bit-count field.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset; asynchronous and active-high.
- s_axis_tdata  in  WIDTH  scrambled bits; bit 0 first in time.
- s_axis_tuser  in  4  rate code (`RATE_*` from ieee80211_defs).
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  2*WIDTH  coded bits, LSB-aligned; unused upper bits zero.
- m_axis_tcount  out  CW  number of valid bits in m_axis_tdata (2*WIDTH, 3*WIDTH/2 or 4*WIDTH/3).
- m_axis_tuser  out  4  rate code in force for this beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.

## Operation
- Rate map: 6M/12M/24M → 1/2; 48M → 2/3; 9M/18M/36M/54M → 3/4; any other code → 1/2, with m_axis_tuser passed through unchanged.
- Frame rate lock: the rate is sampled on the first accepted beat of a frame (after reset or after a tlast beat) and held until the tlast beat. s_axis_tuser on later beats of the frame is ignored.
- Encoding: 6-bit state register, zero at reset. For each input bit b_i in order: A_i = parity(g0 & {b_i,state}), B_i = parity(g1 & {b_i,state}), then the state shifts b_i in.
- Unpunctured order: A0 B0 A1 B1 …, with A0 at bit 0.
- Puncture 2/3: per 2 input bits keep A0 B0 A1 (drop B1).
- Puncture 3/4: per 3 input bits keep A0 B0 A1 B2 (drop B1, A2).
- Kept bits are packed contiguously from bit 0; m_axis_tcount is set accordingly.
- The state register updates only on an accepted input beat. It clears to zero after a beat with tlast, so every frame starts from the zero state.
- An input beat is accepted when s_axis_tvalid && s_axis_tready.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tcount 0, m_axis_tuser 0, m_axis_tlast 0, s_axis_tready 0, state 0, frame lock cleared.
- s_axis_tready rises on the first aclk edge after areset deasserts.
- Latency: an input accepted on edge n appears on m_axis_* after edge n; registered output, 1 cycle.
- Throughput: 1 beat/cycle while m_axis_tready is high.
- Skid buffer: 2 entries (output register + skid register).
  - s_axis_tready = skid empty, a registered signal with no combinational path from m_axis_tready.
  - With m_axis_tready low, two beats are accepted, then s_axis_tready falls.
  - s_axis_tready rises the cycle after the output drains.
- Held output: m_axis_tdata/tcount/tuser/tlast stay stable while tvalid && !tready.
- Simultaneous output pop and input accept: data moves through with no bubble.
- Reset mid-frame: all buffered beats are discarded, state and frame lock clear, and no partial beat is emitted.

## Configuration
- ENCODER_PUNCTURE_EN defined: 2/3 and 3/4 puncturing behave as above.
- ENCODER_PUNCTURE_EN undefined: every rate code encodes at 1/2 (tcount = 2*WIDTH), puncture logic is absent, and tuser still passes through.

## Structure
- ieee80211_defs (shared, included) holds:
  - `RATE_*` codes.
  - Generator constants G0=7'o133 and G1=7'o171.
  - Puncture pattern constants.
  - The rate-to-code-rate mapping function.
- Sub-module encoder_skid: generic 2-entry AXI-Stream skid buffer, parametrised on payload width, carrying {tdata, tcount, tuser, tlast}.
- The encode/puncture datapath is combinational inside conv_encoder, ahead of encoder_skid.

## Test plan
- Half rate: RATE_6M, data 24'h000c8d, tlast=1 → tdata 48'h000e7c40858b, tcount 48, tlast 1, one cycle after acceptance.
- 3/4 streaming: RATE_9M, 10 consecutive beats from vectors/data_after_scrambling.txt with tready held high → each output matches vectors/data_after_encoding.txt in bits [31:0], upper bits 0, tcount 32, no bubbles.
- 2/3: RATE_48M, 24'hffffff from state 0 → tcount 36, bits [47:36] zero, result matches the software model; with the macro undefined → tcount 48.
- Backpressure: m_axis_tready low for 4 cycles while tvalid is held → exactly 2 beats accepted and s_axis_tready low from cycle 3; on release both beats emerge in order with unchanged data, then tready recovers.
- Frame lock and state clear: a two-beat frame with tuser changing 9M→6M mid-frame → both beats coded at 3/4. A repeat of the same frame after tlast → identical output, confirming zero start state.
- Reset mid-frame: assert areset with 2 beats buffered → m_axis_tvalid 0 immediately (asynchronous); after release the first beat of 24'h000c8d yields 48'h000e7c40858b.
